// File: rtl/alu_op_sequencer.sv
// Control sequencer for a register-file ALU datapath: fetches one instruction and
// walks it through the T0..T6 microsteps, driving one-hot register selects and strobes.
module alu_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] IR,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  PCin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  LOin,
    output logic                  HIin,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [4:0]            operation,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Illegal
);

    localparam int unsigned REG_BITS  = $clog2(NUM_REGS);
    localparam int unsigned USED_BITS = 5 + 3 * REG_BITS;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6
    } state_e;

    state_e state_q, state_d;

    logic [4:0]          opcode;
    logic [REG_BITS-1:0] ra, rb, rc;
    logic                is_two, is_wide, is_unary;

    assign opcode = IR[DATA_WIDTH-1 -: 5];
    assign ra     = IR[DATA_WIDTH-6 -: REG_BITS];
    assign rb     = IR[DATA_WIDTH-6-REG_BITS -: REG_BITS];
    assign rc     = IR[DATA_WIDTH-6-2*REG_BITS -: REG_BITS];

    // Low IR bits hold immediates/fields this sequencer never looks at.
    if (DATA_WIDTH > USED_BITS) begin : g_unused_ir
        logic unused_ir;
        assign unused_ir = ^IR[DATA_WIDTH-USED_BITS-1:0];
    end

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_BITS-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == REG_BITS'(i));
        end
        return oh;
    endfunction

    always_comb begin
        is_two   = 1'b0;
        is_wide  = 1'b0;
        is_unary = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_two   = 1'b1;
            OP_MUL, OP_DIV:                  is_wide  = 1'b1;
            OP_NEG, OP_NOT:                  is_unary = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        Rout      = '0;
        Rin       = '0;
        operation = 5'b00000;
        Done      = 1'b0;
        Illegal   = 1'b0;
        Busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (Start) state_d = StT0;
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                // Strobes stay up for the whole memory wait.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (MemReady) state_d = StT2;
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                if (is_two || is_wide) begin
                    Rout    = onehot(rb);
                    Yin     = 1'b1;
                    state_d = StT4;
                end else if (is_unary) begin
                    Rout      = onehot(rb);
                    Zin       = 1'b1;
                    operation = opcode;
                    state_d   = StT4;
                end else begin
                    Illegal = 1'b1;
                    state_d = StIdle;
                end
            end
            StT4: begin
                if (is_unary) begin
                    Zlowout = 1'b1;
                    Rin     = onehot(ra);
                    Done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    Rout      = onehot(rc);
                    Zin       = 1'b1;
                    operation = opcode;
                    state_d   = StT5;
                end
            end
            StT5: begin
                Zlowout = 1'b1;
                if (is_wide) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    Rin     = onehot(ra);
                    Done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
